// File: rtl/dco_tune_enc.sv
// DCO tuning-word encoder: three-phase tuning FSM (PVT -> ACQ -> TRK) that
// freezes each capacitor-bank code outside its phase and drives the
// thermometer-coded row/column matrix controls of the large, medium and small banks.
// Optional feature: define DCO_TUNE_DITHER_EN to enable fractional dithering
// of the small bank via a FRAC_W-bit accumulator in the TRK phase.
module dco_tune_enc #(
    parameter logic [1:0] OSC_GAIN = 2'b10,
    parameter int         L_INIT   = 12,
    parameter int         M_INIT   = 128,
    parameter int         S_INIT   = 128,
    parameter int         FRAC_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              upd,
    input  logic [4:0]        pvt_word,
    input  logic [7:0]        acq_word,
    input  logic [7:0]        trk_word,
    input  logic [FRAC_W-1:0] trk_frac,
    input  logic              pvt_lock,
    input  logic              acq_lock,
    output logic              pd,
    output logic [1:0]        osc_gain,
    output logic [4:0]        c_l_rall,
    output logic [4:0]        c_l_row,
    output logic [4:0]        c_l_col,
    output logic [15:0]       c_m_rall,
    output logic [15:0]       c_m_row,
    output logic [15:0]       c_m_col,
    output logic [15:0]       c_s_rall,
    output logic [15:0]       c_s_row,
    output logic [15:0]       c_s_col,
    output logic [1:0]        mode
);

    typedef enum logic [1:0] {
        ST_PVT = 2'd0,
        ST_ACQ = 2'd1,
        ST_TRK = 2'd2
    } state_t;

    localparam logic [4:0] L_INIT_C = 5'(L_INIT);
    localparam logic [7:0] M_INIT_C = 8'(M_INIT);
    localparam logic [7:0] S_INIT_C = 8'(S_INIT);

    // Large bank: 5x5 matrix, returns {rall, row, col}
    function automatic logic [14:0] enc_l(input logic [4:0] n);
        logic [4:0] rall, row, col;
        int q, r;
        q = int'(n) / 5;
        r = int'(n) % 5;
        for (int i = 0; i < 5; i++) begin
            rall[i] = (i < q);
            row[i]  = (i == q) && (r > 0);
            col[i]  = (i < r);
        end
        return {rall, row, col};
    endfunction

    // Medium/small bank: 16x16 matrix, returns {rall, row, col}
    function automatic logic [47:0] enc_16(input logic [7:0] n);
        logic [15:0] rall, row, col;
        int q, r;
        q = int'(n[7:4]);
        r = int'(n[3:0]);
        for (int i = 0; i < 16; i++) begin
            rall[i] = (i < q);
            row[i]  = (i == q) && (r > 0);
            col[i]  = (i < r);
        end
        return {rall, row, col};
    endfunction

    state_t      state_q, state_d;
    logic        pd_q, pd_d;
    logic [4:0]  l_code_q, l_code_d;
    logic [7:0]  m_code_q, m_code_d;
    logic [7:0]  s_code_q, s_code_d;
    logic [14:0] l_enc_q, l_enc_d;
    logic [47:0] m_enc_q, m_enc_d;
    logic [47:0] s_enc_q, s_enc_d;
    logic [4:0]  pvt_sat;

`ifdef DCO_TUNE_DITHER_EN
    logic [FRAC_W-1:0] acc_q, acc_d;
    logic [7:0]        trk_base_q, trk_base_d;
    logic [FRAC_W:0]   acc_sum;
    logic [7:0]        trk_sel;
    logic [8:0]        s_sum;
`else
    logic              unused_frac;
    assign unused_frac = ^trk_frac;
`endif

    // Phase sequencing: disable forces PVT, locks advance one phase at a time
    always_comb begin
        state_d = state_q;
        if (!en) begin
            state_d = ST_PVT;
        end else begin
            case (state_q)
                ST_PVT:  if (pvt_lock) state_d = ST_ACQ;
                ST_ACQ:  if (acq_lock) state_d = ST_TRK;
                ST_TRK:  state_d = ST_TRK;
                default: state_d = ST_PVT;
            endcase
        end
    end

    // Bank code update: each bank only follows its word in its own phase
    always_comb begin
        pd_d     = !en;
        l_code_d = l_code_q;
        m_code_d = m_code_q;
        s_code_d = s_code_q;
        pvt_sat  = (pvt_word > 5'd25) ? 5'd25 : pvt_word;
`ifdef DCO_TUNE_DITHER_EN
        acc_d      = acc_q;
        trk_base_d = trk_base_q;
        acc_sum    = {1'b0, acc_q} + {1'b0, trk_frac};
        trk_sel    = upd ? trk_word : trk_base_q;
        s_sum      = {1'b0, trk_sel} + {8'd0, acc_sum[FRAC_W]};
`endif
        if (!en) begin
`ifdef DCO_TUNE_DITHER_EN
            acc_d = '0;
`endif
        end else begin
            if (state_q == ST_PVT && upd) l_code_d = pvt_sat;
            if (state_q == ST_ACQ && upd) m_code_d = acq_word;
`ifdef DCO_TUNE_DITHER_EN
            if (state_q == ST_TRK) begin
                acc_d      = acc_sum[FRAC_W-1:0];
                trk_base_d = trk_sel;
                s_code_d   = s_sum[8] ? 8'd255 : s_sum[7:0];
            end
`else
            if (state_q == ST_TRK && upd) s_code_d = trk_word;
`endif
        end
        l_enc_d = enc_l(l_code_d);
        m_enc_d = enc_16(m_code_d);
        s_enc_d = enc_16(s_code_d);
    end

    // State, code and matrix-control registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_PVT;
            pd_q     <= 1'b1;
            l_code_q <= L_INIT_C;
            m_code_q <= M_INIT_C;
            s_code_q <= S_INIT_C;
            l_enc_q  <= enc_l(L_INIT_C);
            m_enc_q  <= enc_16(M_INIT_C);
            s_enc_q  <= enc_16(S_INIT_C);
`ifdef DCO_TUNE_DITHER_EN
            acc_q      <= '0;
            trk_base_q <= S_INIT_C;
`endif
        end else begin
            state_q  <= state_d;
            pd_q     <= pd_d;
            l_code_q <= l_code_d;
            m_code_q <= m_code_d;
            s_code_q <= s_code_d;
            l_enc_q  <= l_enc_d;
            m_enc_q  <= m_enc_d;
            s_enc_q  <= s_enc_d;
`ifdef DCO_TUNE_DITHER_EN
            acc_q      <= acc_d;
            trk_base_q <= trk_base_d;
`endif
        end
    end

    assign {c_l_rall, c_l_row, c_l_col} = l_enc_q;
    assign {c_m_rall, c_m_row, c_m_col} = m_enc_q;
    assign {c_s_rall, c_s_row, c_s_col} = s_enc_q;
    assign pd       = pd_q;
    assign mode     = state_q;
    assign osc_gain = OSC_GAIN;

endmodule

// File: tb/tb_dco_tune_enc.sv
// Self-checking bench for dco_tune_enc: directed literal checks followed by
// randomized stimulus, compared every cycle against a behavioural model.
module tb_dco_tune_enc;

    logic        clk = 1'b0;
    logic        rst, en, upd, pvt_lock, acq_lock;
    logic [4:0]  pvt_word;
    logic [7:0]  acq_word, trk_word, trk_frac;
    logic        pd;
    logic [1:0]  osc_gain, mode;
    logic [4:0]  c_l_rall, c_l_row, c_l_col;
    logic [15:0] c_m_rall, c_m_row, c_m_col;
    logic [15:0] c_s_rall, c_s_row, c_s_col;

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model state: plain integer codes and phase number
    int m_state, m_l, m_m, m_s, m_base, m_acc;
    bit m_pd;
    bit model_valid = 1'b0;

    dco_tune_enc dut (
        .clk(clk), .rst(rst), .en(en), .upd(upd),
        .pvt_word(pvt_word), .acq_word(acq_word), .trk_word(trk_word),
        .trk_frac(trk_frac), .pvt_lock(pvt_lock), .acq_lock(acq_lock),
        .pd(pd), .osc_gain(osc_gain),
        .c_l_rall(c_l_rall), .c_l_row(c_l_row), .c_l_col(c_l_col),
        .c_m_rall(c_m_rall), .c_m_row(c_m_row), .c_m_col(c_m_col),
        .c_s_rall(c_s_rall), .c_s_row(c_s_row), .c_s_col(c_s_col),
        .mode(mode)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] e_rall(int n, int w);
        int q = n / w;
        return 16'((1 << q) - 1);
    endfunction

    function automatic logic [15:0] e_row(int n, int w);
        int q = n / w;
        int r = n % w;
        return (r > 0 && q < w) ? 16'(1 << q) : 16'd0;
    endfunction

    function automatic logic [15:0] e_col(int n, int w);
        int r = n % w;
        return 16'((1 << r) - 1);
    endfunction

    function automatic int s_code_seen();
        return 16 * $countones(c_s_rall) + $countones(c_s_col);
    endfunction

    task automatic check_output(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic r, input logic e, input logic u,
                                  input logic pl, input logic al);
        rst = r; en = e; upd = u; pvt_lock = pl; acq_lock = al;
        step();
    endtask

    // Reference model: phase rules and code arithmetic applied at each clock edge
    always @(posedge clk) begin
        int carry;
        if (rst) begin
            m_state = 0; m_pd = 1'b1;
            m_l = 12; m_m = 128; m_s = 128; m_base = 128; m_acc = 0;
        end else if (!en) begin
            m_state = 0; m_pd = 1'b1; m_acc = 0;
        end else begin
            m_pd = 1'b0;
            case (m_state)
                0: begin
                    if (upd) m_l = (int'(pvt_word) > 25) ? 25 : int'(pvt_word);
                    if (pvt_lock) m_state = 1;
                end
                1: begin
                    if (upd) m_m = int'(acq_word);
                    if (acq_lock) m_state = 2;
                end
                default: begin
`ifdef DCO_TUNE_DITHER_EN
                    if (upd) m_base = int'(trk_word);
                    m_acc = m_acc + int'(trk_frac);
                    carry = (m_acc >= 256) ? 1 : 0;
                    m_acc = m_acc % 256;
                    m_s = (m_base + carry > 255) ? 255 : m_base + carry;
`else
                    carry = 0;
                    if (upd) m_s = int'(trk_word) + carry;
`endif
                end
            endcase
        end
    end

    // Compare process: every output against the model on every cycle
    always @(negedge clk) begin
        if (model_valid) begin
            check_output("pd", 16'(pd), 16'(m_pd));
            check_output("mode", 16'(mode), 16'(m_state));
            check_output("osc_gain", 16'(osc_gain), 16'h0002);
            check_output("l_rall", 16'(c_l_rall), e_rall(m_l, 5));
            check_output("l_row", 16'(c_l_row), e_row(m_l, 5));
            check_output("l_col", 16'(c_l_col), e_col(m_l, 5));
            check_output("m_rall", c_m_rall, e_rall(m_m, 16));
            check_output("m_row", c_m_row, e_row(m_m, 16));
            check_output("m_col", c_m_col, e_col(m_m, 16));
            check_output("s_rall", c_s_rall, e_rall(m_s, 16));
            check_output("s_row", c_s_row, e_row(m_s, 16));
            check_output("s_col", c_s_col, e_col(m_s, 16));
        end
    end

    // Directed sequence with literal expectations, then random traffic
    initial begin
        int hi_cnt;
        int exp_hi;
        rst = 1'b1; en = 1'b0; upd = 1'b0; pvt_lock = 1'b0; acq_lock = 1'b0;
        pvt_word = '0; acq_word = '0; trk_word = '0; trk_frac = '0;
        step();
        model_valid = 1'b1;
        check_output("lit_rst_pd", 16'(pd), 16'd1);
        check_output("lit_rst_mode", 16'(mode), 16'd0);
        check_output("lit_rst_l_row", 16'(c_l_row), 16'h0004);
        check_output("lit_rst_m_rall", c_m_rall, 16'h00FF);

        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check_output("lit_en_pd", 16'(pd), 16'd0);
        check_output("lit_en_l_rall", 16'(c_l_rall), 16'h0003);
        check_output("lit_en_l_col", 16'(c_l_col), 16'h0003);

        pvt_word = 5'd7;
        apply_stimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        check_output("lit_l7_rall", 16'(c_l_rall), 16'h0001);
        check_output("lit_l7_row", 16'(c_l_row), 16'h0002);
        check_output("lit_l7_col", 16'(c_l_col), 16'h0003);

        pvt_word = 5'd30;
        apply_stimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        check_output("lit_lsat_rall", 16'(c_l_rall), 16'h001F);
        check_output("lit_lsat_row", 16'(c_l_row), 16'h0000);

        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        check_output("lit_acq_mode", 16'(mode), 16'd1);

        acq_word = 8'd37; pvt_word = 5'd3;
        apply_stimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        check_output("lit_m37_rall", c_m_rall, 16'h0003);
        check_output("lit_m37_row", c_m_row, 16'h0004);
        check_output("lit_m37_col", c_m_col, 16'h001F);
        check_output("lit_l_frozen", 16'(c_l_rall), 16'h001F);

        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        check_output("lit_trk_mode", 16'(mode), 16'd2);

        trk_word = 8'd100; trk_frac = 8'h40;
        apply_stimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        hi_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
            if (s_code_seen() == 101) hi_cnt++;
        end
`ifdef DCO_TUNE_DITHER_EN
        exp_hi = 2;
`else
        exp_hi = 0;
`endif
        check_output("lit_dither_count", 16'(hi_cnt), 16'(exp_hi));

        trk_word = 8'd255; trk_frac = 8'hFF;
        apply_stimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
            check_output("lit_s_sat", 16'(s_code_seen()), 16'd255);
        end

        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_output("lit_dis_pd", 16'(pd), 16'd1);
        check_output("lit_dis_mode", 16'(mode), 16'd0);
        check_output("lit_dis_hold", 16'(s_code_seen()), 16'd255);

        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        check_output("lit_retrk_mode", 16'(mode), 16'd2);
        apply_stimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        check_output("lit_mrst_mode", 16'(mode), 16'd0);
        check_output("lit_mrst_l_rall", 16'(c_l_rall), 16'h0003);
        check_output("lit_mrst_s_code", 16'(s_code_seen()), 16'd128);

        for (int i = 0; i < 2000; i++) begin
            pvt_word = 5'($urandom_range(0, 31));
            acq_word = 8'($urandom);
            trk_word = 8'($urandom);
            trk_frac = 8'($urandom);
            apply_stimulus(($urandom_range(0, 63) == 0),
                           ($urandom_range(0, 15) != 0),
                           1'($urandom),
                           ($urandom_range(0, 7) == 0),
                           ($urandom_range(0, 7) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
